note_sequencer: RTL
===================

Name: note_sequencer

Overview:
Programmable note sequencer that drives the frequency_control wave generator. It owns a small table of notes, each with a frequency word, a waveform select and a duration in samples. On start it plays the table in order and presents freq_ctrl/sw to the generator. Note duration is counted in generator output handshakes (valid & ready), so timing tracks the sample rate rather than the system clock.

Parameters:
DEPTH_P, 16, number of note table entries; power of two, at least 2.
FREQ_WIDTH_P, 16, width of the frequency control word.
DUR_WIDTH_P, 20, width of the note duration in samples.

Ports:
clk_i  in  1  system clock (12 MHz nominal).
reset_ni  in  1  asynchronous reset, active-low.
wr_en_i  in  1  table write strobe.
wr_addr_i  in  $clog2(DEPTH_P)  table write address.
wr_freq_i  in  FREQ_WIDTH_P  frequency word to write.
wr_wave_i  in  4  waveform one-hot to write (0001 sine, 0010 square, 0100 triangle, 1000 saw, 0000 rest).
wr_dur_i  in  DUR_WIDTH_P  note duration in samples to write.
len_i  in  $clog2(DEPTH_P)+1  number of entries to play; sampled on start.
loop_i  in  1  repeat from entry 0 after the last entry; sampled on start.
start_i  in  1  start playback (single-cycle pulse or level).
stop_i  in  1  abort playback.
sample_fire_i  in  1  generator valid_o & ready_i this cycle.
freq_ctrl_o  out  FREQ_WIDTH_P  frequency word to the generator.
sw_o  out  4  waveform select to the generator.
note_idx_o  out  $clog2(DEPTH_P)  index of the current entry.
busy_o  out  1  high in LOAD and PLAY.
note_start_o  out  1  one-cycle pulse on the first PLAY cycle of each note.
done_o  out  1  one-cycle pulse when a non-looping sequence completes.

Behaviour:
- Reset (asynchronous, reset_ni=0): state IDLE, all outputs 0, duration counter 0, index 0. Table contents are undefined after reset and are not cleared.
- Table: DEPTH_P entries of {freq, wave, dur}.
  - A write occurs when wr_en_i is high at the clock edge. Writes are allowed in any state.
  - A write to the entry currently playing does not affect the registered outputs. It takes effect the next time that entry is loaded.
- FSM states: IDLE, LOAD, PLAY, DONE.
  - IDLE: sw_o=0; freq_ctrl_o holds its last value. On start_i & !stop_i & len_i!=0, capture len and loop, set idx=0, and go to LOAD. A start with len_i=0 is ignored. len_i>DEPTH_P is clamped to DEPTH_P.
  - LOAD (exactly 1 cycle): read entry idx. At the next edge, register freq_ctrl_o, sw_o and note_idx_o, clear the counter, and go to PLAY. Outputs keep their previous values during LOAD.
  - PLAY: each sample_fire_i increments the counter. On the fire that makes the count equal max(dur,1), the note ends:
    - If idx<len-1: idx++ and go to LOAD.
    - Else if loop: idx=0 and go to LOAD.
    - Else: go to DONE.
    - A duration of 0 plays as 1 sample.
  - DONE (1 cycle): done_o=1, sw_o=0, then go to IDLE.
- Latency: start sampled at edge k puts the FSM in LOAD; edge k+1 updates the outputs and puts it in PLAY. note_start_o is high in the cycle after edge k+1.
- sample_fire_i asserted during IDLE, LOAD or DONE is ignored.
- start_i while busy is ignored.
- stop_i in any state: at the next edge go to IDLE with sw_o=0. Pending pulses are suppressed and done_o is not asserted. If start and stop are asserted together, stop wins.
- busy_o = (state==LOAD)|(state==PLAY). note_start_o and done_o are registered outputs.
- Reset asserted mid-sequence returns immediately (asynchronously) to the reset values.

Test Plan:
- Basic: write entries 0..2 = {440,0001,4}, {880,0010,2}, {220,1000,3}; len=3, loop=0; start; fire every 5th cycle -> sw_o sequence 0001/0010/1000; each note held for 4/2/3 fires; note_start_o pulses 3 times; done_o pulses once, after the 9th fire; sw_o=0 afterwards; busy_o drops.
- Loop: same table, loop=1; 20 fires -> note_idx_o follows 0,1,2,0,1,2,0 with wrap from 2 to 0; done_o never pulses; stop -> IDLE next edge, sw_o=0, no done_o.
- Boundaries:
  - dur=0 entry plays exactly 1 fire.
  - start with len_i=0 -> stays IDLE, busy_o=0.
  - len_i=DEPTH_P plays all 16 entries, then done_o.
- Live write: during PLAY of entry 1, write entry 1 freq=1000 -> freq_ctrl_o is unchanged until entry 1 is replayed (loop=1), then shows 1000.
- Start/stop collision and fires outside PLAY: start & stop in the same cycle -> remains IDLE. sample_fire_i on the LOAD cycle -> not counted (note still lasts dur fires after PLAY begins).
- Reset: deassert reset_ni mid-PLAY, asynchronous to the clock -> all outputs 0 immediately; after release, a start plays from entry 0.

Source files
------------

// File: rtl/note_sequencer.sv
// Note sequencer: plays a programmable table of {frequency, waveform, duration}
// entries into the frequency_control wave generator. Note length is counted in
// generator output handshakes so playback timing follows the sample rate.
module note_sequencer #(
  parameter  int DEPTH_P      = 16,
  parameter  int FREQ_WIDTH_P = 16,
  parameter  int DUR_WIDTH_P  = 20,
  localparam int IDX_W        = $clog2(DEPTH_P),
  localparam int LEN_W        = IDX_W + 1
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic                    wr_en_i,
  input  logic [IDX_W-1:0]        wr_addr_i,
  input  logic [FREQ_WIDTH_P-1:0] wr_freq_i,
  input  logic [3:0]              wr_wave_i,
  input  logic [DUR_WIDTH_P-1:0]  wr_dur_i,
  input  logic [LEN_W-1:0]        len_i,
  input  logic                    loop_i,
  input  logic                    start_i,
  input  logic                    stop_i,
  input  logic                    sample_fire_i,
  output logic [FREQ_WIDTH_P-1:0] freq_ctrl_o,
  output logic [3:0]              sw_o,
  output logic [IDX_W-1:0]        note_idx_o,
  output logic                    busy_o,
  output logic                    note_start_o,
  output logic                    done_o
);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, DONE} state_e;

  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH_P);

  // Note table storage; contents survive reset and are only changed by writes.
  logic [FREQ_WIDTH_P-1:0] mem_freq [DEPTH_P];
  logic [3:0]              mem_wave [DEPTH_P];
  logic [DUR_WIDTH_P-1:0]  mem_dur  [DEPTH_P];

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic                    loop_q, loop_d;
  logic [DUR_WIDTH_P-1:0]  cnt_q, cnt_d;
  logic [DUR_WIDTH_P-1:0]  dur_q, dur_d;
  logic [FREQ_WIDTH_P-1:0] freq_q, freq_d;
  logic [3:0]              sw_q, sw_d;
  logic [IDX_W-1:0]        note_idx_q, note_idx_d;
  logic                    note_start_q, note_start_d;
  logic                    done_q, done_d;

  logic [DUR_WIDTH_P-1:0]  cnt_inc;
  logic [DUR_WIDTH_P-1:0]  dur_eff;
  logic                    last_entry;

  // Table write port, usable in every state; the playing note keeps its own copy.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_freq[wr_addr_i] <= wr_freq_i;
      mem_wave[wr_addr_i] <= wr_wave_i;
      mem_dur[wr_addr_i]  <= wr_dur_i;
    end
  end

  assign cnt_inc    = cnt_q + DUR_WIDTH_P'(1);
  assign dur_eff    = (dur_q == '0) ? DUR_WIDTH_P'(1) : dur_q;
  assign last_entry = (({1'b0, idx_q} + LEN_W'(1)) == len_q);

  // Next-state and next-output logic; stop overrides everything else.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    len_d        = len_q;
    loop_d       = loop_q;
    cnt_d        = cnt_q;
    dur_d        = dur_q;
    freq_d       = freq_q;
    sw_d         = sw_q;
    note_idx_d   = note_idx_q;
    note_start_d = 1'b0;
    done_d       = 1'b0;
    if (stop_i) begin
      state_d = IDLE;
      sw_d    = 4'b0000;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i && (len_i != '0)) begin
            state_d = LOAD;
            len_d   = (len_i > DEPTH_L) ? DEPTH_L : len_i;
            loop_d  = loop_i;
            idx_d   = '0;
          end
        end
        LOAD: begin
          freq_d       = mem_freq[idx_q];
          sw_d         = mem_wave[idx_q];
          dur_d        = mem_dur[idx_q];
          note_idx_d   = idx_q;
          cnt_d        = '0;
          note_start_d = 1'b1;
          state_d      = PLAY;
        end
        PLAY: begin
          if (sample_fire_i) begin
            cnt_d = cnt_inc;
            if (cnt_inc == dur_eff) begin
              if (!last_entry) begin
                idx_d   = idx_q + IDX_W'(1);
                state_d = LOAD;
              end else if (loop_q) begin
                idx_d   = '0;
                state_d = LOAD;
              end else begin
                state_d = DONE;
                sw_d    = 4'b0000;
                done_d  = 1'b1;
              end
            end
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Sequencer state and registered outputs, cleared asynchronously on reset.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      len_q        <= '0;
      loop_q       <= 1'b0;
      cnt_q        <= '0;
      dur_q        <= '0;
      freq_q       <= '0;
      sw_q         <= 4'b0000;
      note_idx_q   <= '0;
      note_start_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      len_q        <= len_d;
      loop_q       <= loop_d;
      cnt_q        <= cnt_d;
      dur_q        <= dur_d;
      freq_q       <= freq_d;
      sw_q         <= sw_d;
      note_idx_q   <= note_idx_d;
      note_start_q <= note_start_d;
      done_q       <= done_d;
    end
  end

  assign freq_ctrl_o  = freq_q;
  assign sw_o         = sw_q;
  assign note_idx_o   = note_idx_q;
  assign note_start_o = note_start_q;
  assign done_o       = done_q;
  assign busy_o       = (state_q == LOAD) || (state_q == PLAY);

endmodule
